// File: rtl/mem_2rw_pkg.sv
// Shared constants and port request payload for the 2RW bit-mask memory.
package mem_2rw_pkg;

   localparam int unsigned width_default_lp      = 32;
   localparam int unsigned els_default_lp        = 64;
   localparam int unsigned addr_width_default_lp = $clog2(els_default_lp);

   typedef struct packed {
      logic [width_default_lp-1:0]      data;
      logic [width_default_lp-1:0]      mask;
      logic [addr_width_default_lp-1:0] addr;
      logic                             v;
      logic                             w;
   } mem_2rw_req_t;

endpackage

// File: rtl/clkgate_cell.sv
// Latch-based integrated clock gate; bypass_i forces the clock through.
// Compiled only when MEM_2RW_CLKGATE_EN is defined, the sole build that uses it.
`ifdef MEM_2RW_CLKGATE_EN
module clkgate_cell (
   input  logic clk_i,
   input  logic en_i,
   input  logic bypass_i,
   output logic gated_clock_o
);

   logic en_l;

   // Enable may only change while the clock is low, so the AND never glitches.
   always_latch begin
      if (!clk_i) en_l = en_i | bypass_i;
   end

   assign gated_clock_o = clk_i & en_l;

endmodule
`endif

// File: rtl/mem_2rw_sync_mask_write_bit_synth.sv
// Two-port synchronous SRAM with per-bit write mask and registered read data.
// Define MEM_2RW_CLKGATE_EN to run the array on a clock gated by port activity.
module mem_2rw_sync_mask_write_bit_synth
   import mem_2rw_pkg::*;
#(
   parameter int unsigned width_p       = width_default_lp,
   parameter int unsigned els_p         = els_default_lp,
   parameter int unsigned addr_width_lp = $clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [width_p-1:0]       a_data_i,
   input  logic [width_p-1:0]       a_w_mask_i,
   input  logic [addr_width_lp-1:0] a_addr_i,
   input  logic                     a_v_i,
   input  logic                     a_w_i,
   input  logic [width_p-1:0]       b_data_i,
   input  logic [width_p-1:0]       b_w_mask_i,
   input  logic [addr_width_lp-1:0] b_addr_i,
   input  logic                     b_v_i,
   input  logic                     b_w_i,
   output logic [width_p-1:0]       a_data_o,
   output logic [width_p-1:0]       b_data_o
);

   logic [width_p-1:0] mem [els_p];

   logic               array_clk;
   logic               a_hit, b_hit;
   logic               a_we, b_we;
   logic               a_re, b_re;
   logic [width_p-1:0] a_base, a_word, b_word;

`ifdef MEM_2RW_CLKGATE_EN
   clkgate_cell u_clkgate (
      .clk_i         (clk_i),
      .en_i          (a_v_i | b_v_i),
      .bypass_i      (1'b0),
      .gated_clock_o (array_clk)
   );
`else
   assign array_clk = clk_i;
`endif

   assign a_hit = (32'(a_addr_i) < els_p);
   assign b_hit = (32'(b_addr_i) < els_p);
   assign a_we  = reset_n_i & a_v_i & a_w_i & a_hit;
   assign b_we  = reset_n_i & b_v_i & b_w_i & b_hit;
   assign a_re  = a_v_i & ~a_w_i;
   assign b_re  = b_v_i & ~b_w_i;

   // Port A is merged on top of port B's result so A wins only on bits both ports mask in.
   always_comb begin
      b_word = (mem[b_addr_i] & ~b_w_mask_i) | (b_data_i & b_w_mask_i);
      a_base = (b_we && (b_addr_i == a_addr_i)) ? b_word : mem[a_addr_i];
      a_word = (a_base & ~a_w_mask_i) | (a_data_i & a_w_mask_i);
   end

   always_ff @(posedge array_clk) begin
      if (b_we) mem[b_addr_i] <= b_word;
      if (a_we) mem[a_addr_i] <= a_word;
   end

   // Reads sample the array before this edge's writes land: read-before-write.
   always_ff @(posedge array_clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         a_data_o <= '0;
         b_data_o <= '0;
      end else begin
         if (a_re) a_data_o <= a_hit ? mem[a_addr_i] : '0;
         if (b_re) b_data_o <= b_hit ? mem[b_addr_i] : '0;
      end
   end

endmodule

// File: tb/tb_mem_2rw_sync_mask_write_bit_synth.sv
// Scoreboard bench for mem_2rw_sync_mask_write_bit_synth built with a 48-word array.
module tb_mem_2rw_sync_mask_write_bit_synth;

   localparam int unsigned W  = 32;
   localparam int unsigned E  = 48;
   localparam int unsigned AW = 6;
   localparam logic [W-1:0] F = 32'hFFFF_FFFF;
   localparam logic [W-1:0] Z = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic [W-1:0]  a_data_i, a_w_mask_i, b_data_i, b_w_mask_i;
   logic [AW-1:0] a_addr_i, b_addr_i;
   logic          a_v_i, a_w_i, b_v_i, b_w_i;
   logic [W-1:0]  a_data_o, b_data_o;

   logic [W-1:0]  model [E];
   logic [W-1:0]  qa [$];
   logic [W-1:0]  qb [$];
   logic [W-1:0]  a_hold, b_hold;
   int            n_checks = 0;
   int            n_pass   = 0;

   mem_2rw_sync_mask_write_bit_synth #(.width_p(W), .els_p(E)) dut (
      .clk_i      (clk),
      .reset_n_i  (reset_n_i),
      .a_data_i   (a_data_i),
      .a_w_mask_i (a_w_mask_i),
      .a_addr_i   (a_addr_i),
      .a_v_i      (a_v_i),
      .a_w_i      (a_w_i),
      .b_data_i   (b_data_i),
      .b_w_mask_i (b_w_mask_i),
      .b_addr_i   (b_addr_i),
      .b_v_i      (b_v_i),
      .b_w_i      (b_w_i),
      .a_data_o   (a_data_o),
      .b_data_o   (b_data_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      else n_pass++;
   endtask

   // Drive one cycle on both ports, update the reference at the edge, then score outputs.
   task automatic step(input logic av, input logic aw, input logic [AW-1:0] aa,
                       input logic [W-1:0] ad, input logic [W-1:0] am,
                       input logic bv, input logic bw, input logic [AW-1:0] ba,
                       input logic [W-1:0] bd, input logic [W-1:0] bm);
      a_v_i = av; a_w_i = aw; a_addr_i = aa; a_data_i = ad; a_w_mask_i = am;
      b_v_i = bv; b_w_i = bw; b_addr_i = ba; b_data_i = bd; b_w_mask_i = bm;
      @(posedge clk);
      if (reset_n_i) begin
         if (av && !aw) begin
            if (32'(aa) < E) qa.push_back(model[aa]);
            else qa.push_back(Z);
         end
         if (bv && !bw) begin
            if (32'(ba) < E) qb.push_back(model[ba]);
            else qb.push_back(Z);
         end
         for (int k = 0; k < int'(W); k++) begin
            if (bv && bw && 32'(ba) < E && bm[k]) model[ba][k] = bd[k];
            if (av && aw && 32'(aa) < E && am[k]) model[aa][k] = ad[k];
         end
      end
      #1;
      if (qa.size() > 0) a_hold = qa.pop_front();
      if (qb.size() > 0) b_hold = qb.pop_front();
      check("a_data_o", a_data_o, a_hold);
      check("b_data_o", b_data_o, b_hold);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 6'd0, Z, Z, 1'b0, 1'b0, 6'd0, Z, Z);
   endtask

   initial begin
      a_hold = Z; b_hold = Z;
      reset_n_i = 1'b0;
      a_v_i = 1'b0; a_w_i = 1'b0; a_addr_i = '0; a_data_i = Z; a_w_mask_i = Z;
      b_v_i = 1'b0; b_w_i = 1'b0; b_addr_i = '0; b_data_i = Z; b_w_mask_i = Z;
      #3;
      check("reset_async_a", a_data_o, Z);
      check("reset_async_b", b_data_o, Z);

      // Random activity under reset must neither write nor disturb the outputs.
      for (int i = 0; i < 6; i++)
         step(1'($urandom), 1'($urandom), 6'($urandom_range(0, 47)), 32'($urandom), 32'($urandom),
              1'($urandom), 1'($urandom), 6'($urandom_range(0, 47)), 32'($urandom), 32'($urandom));
      reset_n_i = 1'b1;

      for (int i = 0; i < 24; i++)
         step(1'b1, 1'b1, 6'(i), 32'($urandom), F, 1'b1, 1'b1, 6'(i + 24), 32'($urandom), F);

      // Full-mask write then read on port A.
      step(1'b1, 1'b1, 6'd3, 32'hDEAD_BEEF, F, 1'b0, 1'b0, 6'd0, Z, Z);
      step(1'b1, 1'b0, 6'd3, Z, Z, 1'b0, 1'b0, 6'd0, Z, Z);
      check("read_deadbeef", a_data_o, 32'hDEAD_BEEF);

      // Partial mask clears only the masked byte.
      step(1'b1, 1'b1, 6'd5, F, F, 1'b0, 1'b0, 6'd0, Z, Z);
      step(1'b1, 1'b1, 6'd5, Z, 32'h0000_FF00, 1'b0, 1'b0, 6'd0, Z, Z);
      step(1'b0, 1'b0, 6'd0, Z, Z, 1'b1, 1'b0, 6'd5, Z, Z);
      check("masked_write", b_data_o, 32'hFFFF_00FF);

      // Read-before-write across ports.
      step(1'b1, 1'b1, 6'd7, 32'h1111_1111, F, 1'b0, 1'b0, 6'd0, Z, Z);
      step(1'b1, 1'b1, 6'd7, 32'h2222_2222, F, 1'b1, 1'b0, 6'd7, Z, Z);
      check("rbw_old", b_data_o, 32'h1111_1111);
      step(1'b0, 1'b0, 6'd0, Z, Z, 1'b1, 1'b0, 6'd7, Z, Z);
      check("rbw_new", b_data_o, 32'h2222_2222);

      // Write/write collision: A wins on shared mask bits.
      step(1'b1, 1'b1, 6'd9, 32'hAAAA_AAAA, 32'hFFFF_0000, 1'b1, 1'b1, 6'd9, 32'h5555_5555, F);
      step(1'b1, 1'b0, 6'd9, Z, Z, 1'b1, 1'b0, 6'd9, Z, Z);
      check("collision_a", a_data_o, 32'hAAAA_5555);
      check("collision_b", b_data_o, 32'hAAAA_5555);

      // Output holds through idle cycles and a same-port write.
      step(1'b1, 1'b1, 6'd12, 32'h1234_5678, F, 1'b0, 1'b0, 6'd0, Z, Z);
      step(1'b1, 1'b0, 6'd12, Z, Z, 1'b0, 1'b0, 6'd0, Z, Z);
      idle(); idle(); idle();
      step(1'b1, 1'b1, 6'd12, 32'hCAFE_F00D, F, 1'b0, 1'b0, 6'd0, Z, Z);
      check("hold_a", a_data_o, 32'h1234_5678);
      step(1'b0, 1'b0, 6'd0, Z, Z, 1'b1, 1'b0, 6'd12, Z, Z);
      check("after_hold_b", b_data_o, 32'hCAFE_F00D);

      // Out-of-range write is dropped and read returns zero; last word still works.
      step(1'b1, 1'b1, 6'd50, F, F, 1'b1, 1'b1, 6'd47, 32'h0BAD_CAFE, F);
      step(1'b1, 1'b0, 6'd50, Z, Z, 1'b1, 1'b0, 6'd47, Z, Z);
      check("oob_read", a_data_o, Z);
      check("last_word", b_data_o, 32'h0BAD_CAFE);

      // Both ports read the same word.
      step(1'b1, 1'b0, 6'd3, Z, Z, 1'b1, 1'b0, 6'd3, Z, Z);
      check("dual_read_a", a_data_o, 32'hDEAD_BEEF);
      check("dual_read_b", b_data_o, 32'hDEAD_BEEF);

      // Asynchronous reset mid-run clears outputs without an edge.
      reset_n_i = 1'b0;
      #1;
      check("async_reset_a", a_data_o, Z);
      check("async_reset_b", b_data_o, Z);
      a_hold = Z; b_hold = Z;
      step(1'b1, 1'b1, 6'd3, Z, F, 1'b1, 1'b0, 6'd3, Z, Z);
      reset_n_i = 1'b1;
      step(1'b1, 1'b0, 6'd3, Z, Z, 1'b0, 1'b0, 6'd0, Z, Z);
      check("no_write_in_reset", a_data_o, 32'hDEAD_BEEF);

      for (int i = 0; i < 400; i++)
         step(1'($urandom), 1'($urandom), 6'($urandom_range(0, 55)), 32'($urandom), 32'($urandom),
              1'($urandom), 1'($urandom), 6'($urandom_range(0, 55)), 32'($urandom), 32'($urandom));
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_2rw_sync_mask_write_bit_synth.md
# mem_2rw_sync_mask_write_bit_synth

Two-port synchronous SRAM model. Each port independently reads or writes one word per cycle, with a per-bit write mask. Read data is registered. It is the synthesizable storage core under the team's 2RW bit-mask memory wrapper. An optional integrated clock gate turns the array clock off when neither port is active.

## Interface
- `width_p`, default 32: word width in bits (≥1).
- `els_p`, default 64: number of words (≥2; need not be a power of two).
- `addr_width_lp`, default `$clog2(els_p)`: address width, derived; do not override.
- `clk_i` input, 1 bit: single clock; all state on the rising edge.
- `reset_n_i` input, 1 bit: reset is asynchronous and active-low.
- `a_data_i` input, width_p: port A write data.
- `a_w_mask_i` input, width_p: port A per-bit write enable (1 = write the bit).
- `a_addr_i` input, addr_width_lp: port A word address.
- `a_v_i` input, 1 bit: port A access valid.
- `a_w_i` input, 1 bit: port A write (1) or read (0); ignored unless `a_v_i`.
- `b_data_i`, `b_w_mask_i`, `b_addr_i`, `b_v_i`, `b_w_i`: same as the port A signals, for port B.
- `a_data_o` output, width_p: port A registered read data.
- `b_data_o` output, width_p: port B registered read data.

## Operation
- Array: els_p × width_p storage. Contents are not reset and are unknown after power-up.
- Write (`v=1`, `w=1`): on the clock edge, `mem[addr][k] <= data[k]` for every bit k with `mask[k]=1`. Other bits are unchanged.
- Read (`v=1`, `w=0`): on the clock edge, `data_o <= mem[addr]`.
- `data_o` holds its last value on idle cycles and on write cycles of the same port.
- Read and write to the same address on different ports in one cycle: the read returns the pre-write contents (read-before-write).
- Both ports write the same address in one cycle: for bits with both masks set, port A's value is stored. Bits with only one mask set take that port's value.
- Both ports read the same address: both return the same word.
- Address ≥ els_p: a write is discarded, and a read loads all zeros into `data_o`.

## Timing
- `reset_n_i=0` asynchronously forces `a_data_o` and `b_data_o` to 0. While reset is asserted, no writes occur and the outputs stay 0.
- Deassertion takes effect at the next rising edge.
- Read latency is 1 cycle: the address is sampled at edge N and data is valid after edge N.
- A write at edge N is visible to a read issued at edge N+1 or later.
- Full throughput on both ports every cycle. No handshake and no stall.

## Configuration
- Macro `MEM_2RW_CLKGATE_EN`.
- Defined: the array and output registers run on a gated clock. The enable is `a_v_i | b_v_i`, captured by a latch that is transparent while `clk_i` is low, then ANDed with `clk_i`. Result: glitch-free, and no edges on cycles where neither port is valid.
- Not defined: registers run on `clk_i` directly.
- Functional behaviour at the ports is identical in both builds. Asynchronous reset is unaffected by gating.

## Structure
- A shared package `mem_2rw_pkg` holds:
  - the default width and depth constants;
  - a typedef for the port request struct {data, mask, addr, v, w}.
- One sub-module, `clkgate_cell`, with ports `clk_i`, `en_i`, `bypass_i`, `gated_clock_o`.
  - Latch-based ICG; `bypass_i=1` forces the clock to pass.
  - Instantiated only under `MEM_2RW_CLKGATE_EN`, with `bypass_i` tied to 0.

## Test plan
- Reset: hold `reset_n_i=0` with random port activity -> both outputs 0. Release, then port A reads address 3 after a full-mask write of 0xDEADBEEF -> `a_data_o=0xDEADBEEF` one cycle later.
- Masked write: write address 5 = 0xFFFFFFFF (full mask), then 0x00000000 with mask 0x0000FF00 -> port B read of address 5 gives 0xFFFF00FF.
- Cross-port same-cycle: mem[7]=0x11111111. Port A writes 0x22222222 (full mask) while port B reads 7 -> `b_data_o=0x11111111`. A B read of 7 the next cycle gives 0x22222222.
- Write/write collision on address 9: A writes 0xAAAAAAAA mask 0xFFFF0000, B writes 0x55555555 mask 0xFFFFFFFF -> mem[9]=0xAAAA5555.
- Hold: after a read of 0x12345678, idle cycles and a same-port write -> `data_o` stays 0x12345678. With the macro defined, the gated clock shows no edges during the idle cycles.
- `els_p=48`: write to address 50 is discarded, and a read of 50 -> 0.
